// File: rtl/demux_pkg.sv
// demux_pkg: shared channel count, select encodings and word types for the 1:3 demux.
package demux_pkg;
  localparam int NUM_CH = 3;
  localparam int WORD_W = 32;
  typedef logic [1:0] ch_sel_t;
  typedef logic [WORD_W-1:0] word_t;
  localparam ch_sel_t SEL_CH0 = 2'b00;
  localparam ch_sel_t SEL_CH1 = 2'b01;
  localparam ch_sel_t SEL_CH2 = 2'b10;
  // 2'b11 falls through to ch2, matching the 3:1 result-select mux
  function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t s);
    return (s == SEL_CH0) ? 3'b001 : (s == SEL_CH1) ? 3'b010 : 3'b100;
  endfunction
endpackage

// File: rtl/chan_buf_32.sv
// chan_buf_32: one-entry valid/ready holding register for a single demux output channel.
module chan_buf_32
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  word_t i_data,
  input  logic  i_ready,
  output word_t o_data,
  output logic  o_valid
);
  word_t r_data;
  logic  r_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

// File: rtl/demux_1_3_32_buf.sv
// demux_1_3_32_buf: registered 1:3 valid/ready demux; define DEMUX_STATS_EN for per-channel saturating counters.
module demux_1_3_32_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DEMUX_STATS_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  ch_sel_t          in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready
);
  logic [NUM_CH-1:0] w_hot, w_valid, w_ready, w_load;
  word_t             w_data [NUM_CH];
  assign w_hot   = sel_onehot(in_sel);
  assign w_ready = {out2_ready, out1_ready, out0_ready};
  // ready looks only at the addressed channel so a stalled neighbour never blocks
  assign in_ready = |(w_hot & (~w_valid | w_ready));
  assign w_load   = (in_valid && in_ready) ? w_hot : '0;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    chan_buf_32 u_buf (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load[c]),
      .i_data (in_data),
      .i_ready(w_ready[c]),
      .o_data (w_data[c]),
      .o_valid(w_valid[c])
    );
  end
  assign out0_data  = w_data[0];
  assign out1_data  = w_data[1];
  assign out2_data  = w_data[2];
  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out2_valid = w_valid[2];
`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_cnt [NUM_CH];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) r_cnt[c] <= '0;
      else if (w_load[c] && r_cnt[c] != '1) r_cnt[c] <= r_cnt[c] + 1'b1;
    end
  end
  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
`endif
endmodule

// File: tb/tb_demux_1_3_32_buf.sv
// tb_demux_1_3_32_buf: directed vector table plus randomized traffic against a queue-based channel model.
module tb_demux_1_3_32_buf;
  import demux_pkg::*;
  localparam int CNT_W = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  ch_sel_t     in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data [3];
  logic        out_valid [3];
  logic [2:0]  out_ready = 3'b111;
`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt [3];
`endif
  demux_1_3_32_buf #(.WIDTH(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
`ifdef DEMUX_STATS_EN
    .cnt0(cnt[0]), .cnt1(cnt[1]), .cnt2(cnt[2]),
`endif
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out_data[0]), .out0_valid(out_valid[0]), .out0_ready(out_ready[0]),
    .out1_data(out_data[1]), .out1_valid(out_valid[1]), .out1_ready(out_ready[1]),
    .out2_data(out_data[2]), .out2_valid(out_valid[2]), .out2_ready(out_ready[2])
  );
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] mq [3][$];
  int          mcnt [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int dest(input ch_sel_t s);
    return (s > 2'd1) ? 2 : int'(s);
  endfunction

  task automatic step(input logic rs, input logic v, input ch_sel_t s, input logic [31:0] d,
                      input logic [2:0] r, output logic rdy_seen);
    int  ch;
    logic acc;
    rst = rs; in_valid = v; in_sel = s; in_data = d; out_ready = r;
    #1;
    ch  = dest(s);
    acc = v && (mq[ch].size() == 0 || r[ch]);
    rdy_seen = in_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (mq[ch].size() == 0 || r[ch])});
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (rs) begin
        mq[c].delete();
        mcnt[c] = 0;
      end else begin
        if (mq[c].size() != 0 && r[c]) void'(mq[c].pop_front());
        if (acc && c == ch) begin
          mq[c].push_back(d);
          if (mcnt[c] < (1 << CNT_W) - 1) mcnt[c]++;
        end
      end
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("out%0d_valid", c), {31'd0, out_valid[c]}, {31'd0, mq[c].size() != 0});
      if (mq[c].size() != 0) chk($sformatf("out%0d_data", c), out_data[c], mq[c][0]);
`ifdef DEMUX_STATS_EN
      chk($sformatf("cnt%0d", c), {{(32 - CNT_W){1'b0}}, cnt[c]}, mcnt[c]);
`endif
    end
    @(negedge clk);
  endtask

  typedef struct {
    ch_sel_t     sel;
    logic [31:0] d;
    logic        v;
    logic [2:0]  r;
    logic        er;
    logic [2:0]  ev;
    int          cc;
    logic [31:0] ed;
  } vec_t;
  vec_t vt [10];

  initial begin
    logic rdy;
    vt[0] = '{2'b01, 32'hDEADBEEF, 1, 3'b111, 1, 3'b010, 1, 32'hDEADBEEF};
    vt[1] = '{2'b01, 32'h0,        0, 3'b111, 1, 3'b000, 3, 32'h0};
    vt[2] = '{2'b10, 32'h11,       1, 3'b011, 1, 3'b100, 2, 32'h11};
    vt[3] = '{2'b10, 32'h22,       1, 3'b011, 0, 3'b100, 2, 32'h11};
    vt[4] = '{2'b10, 32'h22,       1, 3'b111, 1, 3'b100, 2, 32'h22};
    vt[5] = '{2'b10, 32'h0,        0, 3'b111, 1, 3'b000, 3, 32'h0};
    vt[6] = '{2'b00, 32'hAA,       1, 3'b110, 1, 3'b001, 0, 32'hAA};
    vt[7] = '{2'b01, 32'h5,        1, 3'b110, 1, 3'b011, 1, 32'h5};
    vt[8] = '{2'b00, 32'hBB,       1, 3'b110, 0, 3'b001, 0, 32'hAA};
    vt[9] = '{2'b00, 32'h0,        0, 3'b111, 1, 3'b000, 3, 32'h0};
    @(negedge clk);
    step(1, 1, 2'b01, 32'h1234, 3'b111, rdy);
    step(1, 1, 2'b10, 32'h5678, 3'b111, rdy);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 3; c++) chk($sformatf("rst_data%0d", c), out_data[c], 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(0, vt[i].v, vt[i].sel, vt[i].d, vt[i].r, rdy);
      chk($sformatf("vec%0d_in_ready", i), {31'd0, rdy}, {31'd0, vt[i].er});
      chk($sformatf("vec%0d_valids", i), {29'd0, out_valid[2], out_valid[1], out_valid[0]}, {29'd0, vt[i].ev});
      if (vt[i].cc < 3) chk($sformatf("vec%0d_data", i), out_data[vt[i].cc], vt[i].ed);
    end
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 2'b11, i, 3'b111, rdy);
      chk("stream_in_ready", {31'd0, rdy}, 32'd1);
      chk("stream_data", out_data[2], i);
    end
    step(0, 1, 2'b01, 32'h77, 3'b101, rdy);
    step(1, 1, 2'b01, 32'h88, 3'b101, rdy);
    chk("midrst_out1_valid", {31'd0, out_valid[1]}, 32'd0);
    chk("midrst_out1_data", out_data[1], 32'h0);
`ifdef DEMUX_STATS_EN
    for (int i = 0; i < 20; i++) step(0, 1, 2'b00, i, 3'b111, rdy);
    chk("sat_cnt0", {28'd0, cnt[0]}, 32'hF);
    chk("sat_cnt1", {28'd0, cnt[1]}, 32'h0);
    chk("sat_cnt2", {28'd0, cnt[2]}, 32'h0);
    step(1, 1, 2'b01, 32'h9, 3'b111, rdy);
    chk("rst_cnt0", {28'd0, cnt[0]}, 32'h0);
`endif
    for (int i = 0; i < 1500; i++)
      step($urandom_range(99) == 0, $urandom_range(3) != 0, 2'($urandom_range(3)), $urandom,
           3'($urandom_range(7)), rdy);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
